// File: rtl/lut4_sweep_checker.sv
// Exhaustive LUT4 tester: walks all 16 input vectors, lets each one settle, compares the
// LUT response with the expected truth table, and reports the mismatch count, the first
// failing vector and an overall pass flag.
module lut4_sweep_checker #(
   parameter logic [15:0] TRUTH_TABLE   = 16'hFF5F,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] lut_i,
   input  logic       lut_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [3:0] first_fail
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

   localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [4:0] err_q, err_d;
   logic [3:0] ff_q, ff_d;
   logic       pass_q, pass_d;
   logic       done_q, done_d;
   logic       mismatch;

   assign mismatch = (lut_o != TRUTH_TABLE[idx_q]);

   // Next-state and result updates for the sweep sequencer.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ff_d    = ff_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRIVE;
               idx_d   = 4'd0;
               cnt_d   = 8'd0;
               err_d   = 5'd0;
               ff_d    = 4'd0;
               pass_d  = 1'b0;
            end
         end
         DRIVE: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SettleLast) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            if (mismatch) begin
               if (err_q != 5'd16) begin
                  err_d = err_q + 5'd1;
               end
               if (err_q == 5'd0) begin
                  ff_d = idx_q;
               end
            end
            // idx stops at 15 so lut_i keeps showing the last vector afterwards.
            if (idx_q == 4'd15) begin
               state_d = FINISH;
            end else begin
               state_d = DRIVE;
               idx_d   = idx_q + 4'd1;
               cnt_d   = 8'd0;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            pass_d  = (err_q == 5'd0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low reset; reset also swallows any start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         cnt_q   <= 8'd0;
         err_q   <= 5'd0;
         ff_q    <= 4'd0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   assign lut_i      = idx_q;
   assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

endmodule

// File: tb/tb_lut4_sweep_checker.sv
// Directed bench for lut4_sweep_checker: a behavioural LUT model with selectable faults,
// a result scoreboard popped on every done pulse, and a per-vector SAMPLE-slot monitor.
module tb_lut4_sweep_checker;

   localparam logic [15:0] TT = 16'hFF5F;
   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst_n, start, start2;
   logic [3:0] lut_i, lut_i2;
   logic       lut_o, lut_o2;
   logic       busy, done, pass, busy2, done2, pass2;
   logic [4:0] err_count, err_count2;
   logic [3:0] first_fail, first_fail2;

   int mode = 0;
   int cyc = 0;
   int t_start = 0;
   int total = 0;
   int bad = 0;
   int done_seen = 0;
   bit check_vec = 1'b0;

   typedef struct {
      logic [4:0] err;
      logic [3:0] ff;
      logic       pass;
      int         lat;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // LUT model: 0 good, 1 stuck-at-1, 2 vector 9 inverted, 3 stuck-at-0.
   function automatic logic model(input logic [3:0] v, input int m);
      logic [15:0] tt;
      tt = TT;
      case (m)
         1:       return 1'b1;
         2:       return tt[v] ^ (v == 4'd9);
         3:       return 1'b0;
         default: return tt[v];
      endcase
   endfunction

   assign lut_o  = model(lut_i, mode);
   assign lut_o2 = model(lut_i2, 0);

   lut4_sweep_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .lut_i(lut_i), .lut_o(lut_o),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_fail(first_fail)
   );

   lut4_sweep_checker #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .lut_i(lut_i2), .lut_o(lut_o2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
      .first_fail(first_fail2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_seen++;
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL spurious_done: observed=1 expected=0 at cycle %0d", cyc);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("err_count", 32'(err_count), 32'(e.err));
            chk("first_fail", 32'(first_fail), 32'(e.ff));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("latency", 32'(cyc - t_start - 1), 32'(e.lat));
         end
      end
   end

   // In each SAMPLE slot of a sweep, lut_i must show the vector index, in order.
   always @(negedge clk) begin
      int r;
      r = cyc - t_start - 1;
      if (check_vec && r >= S && r < 16 * (S + 1) && ((r - S) % (S + 1)) == 0) begin
         chk("sample_lut_i", 32'(lut_i), 32'((r - S) / (S + 1)));
         chk("sample_busy", 32'(busy), 32'd1);
      end
   end

   task automatic run_sweep(input int m, input int e_err, input int e_ff, input bit e_pass,
                            input bit repulse);
      int d0;
      exp_t e;
      mode = m;
      d0 = done_seen;
      e.err = 5'(e_err);
      e.ff = 4'(e_ff);
      e.pass = e_pass;
      e.lat = 16 * (S + 1) + 1;
      sb.push_back(e);
      t_start = cyc;
      check_vec = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (repulse) begin
         repeat (20) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL done_timeout: observed=no_done expected=done");
         sb.delete();
      end
      check_vec = 1'b0;
      chk("idle_lut_i", 32'(lut_i), 32'hF);
      chk("idle_busy", 32'(busy), 32'd0);
      repeat (6) @(negedge clk);
      chk("hold_pass", 32'(pass), 32'(e_pass));
      chk("hold_err", 32'(err_count), 32'(e_err));
      chk("hold_ff", 32'(first_fail), 32'(e_ff));
      chk("done_count", 32'(done_seen - d0), 32'd1);
   endtask

   initial begin
      int d0;
      int lat;
      int t2;
      rst_n = 1'b0;
      start = 1'b1;
      start2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_ff", 32'(first_fail), 32'd0);
      chk("rst_lut_i", 32'(lut_i), 32'd0);
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("start_in_reset_ignored", 32'(busy), 32'd0);

      run_sweep(0, 0, 0, 1'b1, 1'b0);
      run_sweep(1, 2, 5, 1'b0, 1'b0);
      run_sweep(2, 1, 9, 1'b0, 1'b0);
      run_sweep(3, 14, 0, 1'b0, 1'b1);

      // Reset partway through a sweep must abort it silently.
      mode = 0;
      t_start = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      chk("pre_abort_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_lut_i", 32'(lut_i), 32'd0);
      chk("abort_err", 32'(err_count), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      d0 = done_seen;
      repeat (100) @(negedge clk);
      chk("abort_no_done", 32'(done_seen - d0), 32'd0);
      run_sweep(0, 0, 0, 1'b1, 1'b0);

      // Minimum settle time instance.
      lat = -1;
      t2 = cyc;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done2 === 1'b1) begin
            lat = cyc - t2 - 1;
            break;
         end
         @(negedge clk);
      end
      chk("s1_latency", 32'(lat), 32'd33);
      chk("s1_pass", 32'(pass2), 32'd1);
      chk("s1_err", 32'(err_count2), 32'd0);
      chk("s1_ff", 32'(first_fail2), 32'd0);
      chk("s1_lut_i", 32'(lut_i2), 32'hF);
      chk("s1_busy", 32'(busy2), 32'd0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
